// File: rtl/ccff_chain_loader.sv
// Loads a configuration-flip-flop chain from an 8-bit bitstream, then recirculates the chain once
// to confirm its contents via a CRC-8 comparison of shifted-in versus shifted-out bits.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter logic [7:0]  CRC_INIT  = 8'h00
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       ccff_head,
    output logic       ccff_shift_en,
    input  logic       ccff_tail,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
    localparam logic [CntW-1:0] ChainLenC = CntW'(CHAIN_LEN);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StVerify = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]      sr_q, sr_d;
    logic [3:0]      bits_left_q, bits_left_d;
    logic [7:0]      crc_in_q, crc_in_d;
    logic [7:0]      crc_out_q, crc_out_d;
    logic            error_q, error_d;
    logic            last_bit;
    logic [31:0]     remaining;
    logic [3:0]      byte_bits;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign last_bit  = (bit_cnt_q == ChainLenC - 1'b1);
    assign remaining = CHAIN_LEN - 32'(bit_cnt_q);
    // The final byte only carries the bits still owed to the chain; its tail is dropped.
    assign byte_bits = (remaining >= 32'd8) ? 4'd8 : remaining[3:0];

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        sr_d          = sr_q;
        bits_left_d   = bits_left_q;
        crc_in_d      = crc_in_q;
        crc_out_d     = crc_out_q;
        error_d       = error_q;
        cfg_ready     = 1'b0;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    error_d     = 1'b0;
                    crc_in_d    = CRC_INIT;
                    crc_out_d   = CRC_INIT;
                    bit_cnt_d   = '0;
                    bits_left_d = 4'd0;
                end
            end
            StLoad: begin
                busy = 1'b1;
                if (bits_left_q == 4'd0) begin
                    cfg_ready = 1'b1;
                    if (cfg_valid) begin
                        sr_d        = cfg_data;
                        bits_left_d = byte_bits;
                    end
                end else begin
                    ccff_head     = sr_q[7];
                    ccff_shift_en = 1'b1;
                    sr_d          = {sr_q[6:0], 1'b0};
                    bits_left_d   = bits_left_q - 4'd1;
                    crc_in_d      = crc8_step(crc_in_q, sr_q[7]);
                    if (last_bit) begin
                        state_d   = StVerify;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StVerify: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                crc_out_d     = crc8_step(crc_out_q, ccff_tail);
                if (last_bit) begin
                    state_d   = StDone;
                    bit_cnt_d = '0;
                    error_d   = error_q | (crc_out_d != crc_in_q);
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            sr_q        <= 8'h00;
            bits_left_q <= 4'd0;
            crc_in_q    <= 8'h00;
            crc_out_q   <= 8'h00;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            bits_left_q <= bits_left_d;
            crc_in_q    <= crc_in_d;
            crc_out_q   <= crc_out_d;
            error_q     <= error_d;
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: two loaders (8- and 12-flop chains) each driving a behavioural chain model.
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    logic p_reset = 1'b1;
    always #5 clk = ~clk;

    // 8-flop instance
    logic       start_a = 1'b0, valid_a = 1'b0, inv_a = 1'b0;
    logic [7:0] data_a = 8'h00, chain_a = 8'h00;
    logic       ready_a, head_a, sen_a, tail_a, busy_a, done_a, err_a;
    // 12-flop instance
    logic        start_b = 1'b0, valid_b = 1'b0;
    logic [7:0]  data_b = 8'h00;
    logic [11:0] chain_b = 12'h000;
    logic        ready_b, head_b, sen_b, tail_b, busy_b, done_b, err_b;

    int n_vec = 0;
    int n_err = 0;

    ccff_chain_loader #(.CHAIN_LEN(8), .CRC_INIT(8'h00)) u_dut_a (
        .prog_clk(clk), .pReset(p_reset), .start(start_a), .cfg_data(data_a),
        .cfg_valid(valid_a), .cfg_ready(ready_a), .ccff_head(head_a), .ccff_shift_en(sen_a),
        .ccff_tail(tail_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .CRC_INIT(8'h00)) u_dut_b (
        .prog_clk(clk), .pReset(p_reset), .start(start_b), .cfg_data(data_b),
        .cfg_valid(valid_b), .cfg_ready(ready_b), .ccff_head(head_b), .ccff_shift_en(sen_b),
        .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    // Chain models: head enters flop 0, tail is the last flop.
    always_ff @(posedge clk) begin
        if (sen_a) chain_a <= {chain_a[6:0], head_a};
        if (sen_b) chain_b <= {chain_b[10:0], head_b};
    end
    assign tail_a = chain_a[7] ^ inv_a;
    assign tail_b = chain_b[11];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One full load of the 8-flop chain; T0 is the start cycle.
    task automatic load_a(input logic [7:0] b, input int flip_t, input int pulse_t,
                          input logic exp_err);
        int dones;
        dones = 0;
        @(negedge clk);
        start_a = 1'b1; valid_a = 1'b1; data_a = b;
        for (int t = 1; t <= 21; t++) begin
            @(negedge clk);
            start_a = (t == pulse_t);
            inv_a   = (t == flip_t);
            valid_a = (t <= 9);
            dones  += int'(done_a);
            if (t == 1) begin
                check("a_accept_ready", ready_a, 1);
                check("a_accept_sen", sen_a, 0);
                check("a_busy", busy_a, 1);
                check("a_err_cleared", err_a, 0);
            end else if (t <= 9) begin
                check("a_load_sen", sen_a, 1);
                check("a_load_head", head_a, b[9-t]);
                check("a_load_ready", ready_a, 0);
            end else if (t <= 17) begin
                check("a_verify_sen", sen_a, 1);
                check("a_verify_recirc", head_a, tail_a);
                check("a_verify_ready", ready_a, 0);
            end else if (t == 18) begin
                check("a_done", done_a, 1);
                check("a_error", err_a, exp_err);
                check("a_busy_done", busy_a, 0);
            end else begin
                check("a_idle_busy", busy_a, 0);
                check("a_idle_done", done_a, 0);
            end
        end
        check("a_done_count", dones, 1);
        if (!exp_err) check("a_chain", chain_a, b);
    endtask

    // Two-byte load of the 12-flop chain with an optional gap before the second byte.
    task automatic load_b(input logic [7:0] b0, input logic [7:0] b1, input int gap);
        logic [11:0] w;
        w = {b0, b1[7:4]};
        @(negedge clk);
        start_b = 1'b1; valid_b = 1'b1; data_b = b0;
        for (int t = 1; t <= 28 + gap; t++) begin
            @(negedge clk);
            start_b = 1'b0;
            valid_b = (t <= 10 + gap) && !(t >= 10 && t < 10 + gap);
            if (t >= 2) data_b = b1;
            if (t == 1) begin
                check("b_accept0", ready_b, 1);
            end else if (t <= 9) begin
                check("b_load0_sen", sen_b, 1);
                check("b_load0_head", head_b, w[11-(t-2)]);
            end else if (t < 10 + gap) begin
                check("b_gap_sen", sen_b, 0);
                check("b_gap_head", head_b, 0);
                check("b_gap_ready", ready_b, 1);
            end else if (t == 10 + gap) begin
                check("b_accept1_ready", ready_b, 1);
                check("b_accept1_sen", sen_b, 0);
            end else if (t <= 14 + gap) begin
                check("b_load1_sen", sen_b, 1);
                check("b_load1_head", head_b, w[11-(t-3-gap)]);
            end else if (t <= 26 + gap) begin
                check("b_verify_sen", sen_b, 1);
                check("b_verify_ready", ready_b, 0);
                check("b_verify_head", head_b, w[11-(t-15-gap)]);
            end else if (t == 27 + gap) begin
                check("b_done", done_b, 1);
                check("b_error", err_b, 0);
            end else begin
                check("b_idle_done", done_b, 0);
            end
        end
        check("b_chain", chain_b, w);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", ready_a, 0);
        check("rst_head", head_a, 0);
        check("rst_sen", sen_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_error", err_a, 0);
        p_reset = 1'b0;

        // cfg_valid in IDLE is ignored
        valid_a = 1'b1; data_a = 8'hFF;
        @(negedge clk);
        check("idle_ready", ready_a, 0);
        check("idle_busy", busy_a, 0);
        valid_a = 1'b0;

        load_a(8'hA5, -1, -1, 1'b0);
        load_b(8'hAB, 8'hC0, 0);
        load_b(8'h3C, 8'h90, 5);

        // Corrupt one recirculated bit: error must flag and stay until the next start.
        load_a(8'h5A, 13, -1, 1'b1);
        repeat (3) @(negedge clk);
        check("err_sticky", err_a, 1);
        load_a(8'hA5, -1, -1, 1'b0);

        // start pulsed during VERIFY has no effect
        load_a(8'h96, -1, 12, 1'b0);
        @(negedge clk);
        check("post_busy", busy_a, 0);

        // Reset during the third shifted bit
        @(negedge clk);
        start_a = 1'b1; valid_a = 1'b1; data_a = 8'hA5;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        p_reset = 1'b1;
        @(negedge clk);
        p_reset = 1'b0; valid_a = 1'b0;
        check("mid_rst_ready", ready_a, 0);
        check("mid_rst_head", head_a, 0);
        check("mid_rst_sen", sen_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_error", err_a, 0);

        // start together with reset is ignored
        p_reset = 1'b1; start_a = 1'b1;
        @(negedge clk);
        p_reset = 1'b0; start_a = 1'b0;
        check("start_in_rst", busy_a, 0);
        load_a(8'h3C, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
